// File: rtl/header_tx.sv
// Serialises one 104-bit 5-tuple into four strobed 32-bit header words (sa, da, sp_dp, prot)
// framed by soh/eoh, with per-word hReady back-pressure, an optional post-header gap and counters.
module header_tx #(
    parameter int GAP   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [103:0]     in_tuple,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      data,
    output logic             sa,
    output logic             da,
    output logic             sp_dp,
    output logic             prot,
    output logic             soh,
    output logic             eoh,
    input  logic             hReady,
    output logic [CNT_W-1:0] hdr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SA   = 3'd1;
    localparam logic [2:0] S_DA   = 3'd2;
    localparam logic [2:0] S_SPDP = 3'd3;
    localparam logic [2:0] S_PROT = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam logic       GAP_ZERO = (GAP == 0);
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [2:0]       state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic [103:0]     tuple_q, tuple_d;
    logic [31:0]      data_q, data_d;
    logic             sa_q, sa_d, da_q, da_d, sp_dp_q, sp_dp_d, prot_q, prot_d;
    logic             soh_q, soh_d, eoh_q, eoh_d;
    logic [CNT_W-1:0] hdr_cnt_q, hdr_cnt_d, stall_cnt_q, stall_cnt_d;
    logic             strobe_on;
    logic             accept;

    assign strobe_on = sa_q | da_q | sp_dp_q | prot_q;
    // Holding in_ready low during reset keeps upstream from believing a tuple was taken.
    assign in_ready  = rst_n & ((state_q == S_IDLE) |
                                ((state_q == S_PROT) & hReady & GAP_ZERO));
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        tuple_d     = accept ? in_tuple : tuple_q;
        hdr_cnt_d   = hdr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_SA;
            S_SA:   if (hReady) state_d = S_DA;
            S_DA:   if (hReady) state_d = S_SPDP;
            S_SPDP: if (hReady) state_d = S_PROT;
            S_PROT: begin
                if (hReady) begin
                    if (!GAP_ZERO) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end else if (accept) begin
                        state_d = S_SA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (prot_q && hReady)      hdr_cnt_d   = hdr_cnt_q + CNT_W'(1);
        if (strobe_on && !hReady)  stall_cnt_d = stall_cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they appear registered with the state.
        sa_d    = (state_d == S_SA);
        da_d    = (state_d == S_DA);
        sp_dp_d = (state_d == S_SPDP);
        prot_d  = (state_d == S_PROT);
        soh_d   = sa_d;
        eoh_d   = prot_d;
        case (state_d)
            S_SA:    data_d = tuple_d[103:72];
            S_DA:    data_d = tuple_d[71:40];
            S_SPDP:  data_d = tuple_d[39:8];
            S_PROT:  data_d = {24'h0, tuple_d[7:0]};
            default: data_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gap_q       <= 4'd0;
            tuple_q     <= '0;
            data_q      <= 32'h0;
            sa_q        <= 1'b0;
            da_q        <= 1'b0;
            sp_dp_q     <= 1'b0;
            prot_q      <= 1'b0;
            soh_q       <= 1'b0;
            eoh_q       <= 1'b0;
            hdr_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            tuple_q     <= tuple_d;
            data_q      <= data_d;
            sa_q        <= sa_d;
            da_q        <= da_d;
            sp_dp_q     <= sp_dp_d;
            prot_q      <= prot_d;
            soh_q       <= soh_d;
            eoh_q       <= eoh_d;
            hdr_cnt_q   <= hdr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign data      = data_q;
    assign sa        = sa_q;
    assign da        = da_q;
    assign sp_dp     = sp_dp_q;
    assign prot      = prot_q;
    assign soh       = soh_q;
    assign eoh       = eoh_q;
    assign hdr_cnt   = hdr_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_header_tx.sv
// Directed bench for header_tx: a GAP=0/CNT_W=4 instance for framing, stalls, reset and wrap,
// and a GAP=2 instance for the post-header idle spacing.
module tb_header_tx;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [103:0] in_tuple = '0;
    logic         in_valid = 1'b0;
    logic         hReady = 1'b1;
    logic         in_ready;
    logic [31:0]  data;
    logic         sa, da, sp_dp, prot, soh, eoh;
    logic [3:0]   hdr_cnt, stall_cnt;

    logic [103:0] g_tuple = '0;
    logic         g_valid = 1'b0;
    logic         g_ready;
    logic [31:0]  g_data;
    logic         g_sa, g_da, g_sp_dp, g_prot, g_soh, g_eoh;
    logic [15:0]  g_hdr_cnt, g_stall_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    header_tx #(.GAP(0), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_tuple(in_tuple), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .sa(sa), .da(da), .sp_dp(sp_dp), .prot(prot), .soh(soh), .eoh(eoh),
        .hReady(hReady), .hdr_cnt(hdr_cnt), .stall_cnt(stall_cnt)
    );

    header_tx #(.GAP(2), .CNT_W(16)) u_gap (
        .clk(clk), .rst_n(rst_n), .in_tuple(g_tuple), .in_valid(g_valid), .in_ready(g_ready),
        .data(g_data), .sa(g_sa), .da(g_da), .sp_dp(g_sp_dp), .prot(g_prot), .soh(g_soh),
        .eoh(g_eoh), .hReady(1'b1), .hdr_cnt(g_hdr_cnt), .stall_cnt(g_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // {soh, sa, da, sp_dp, prot, eoh} for word index w; anything else means idle.
    function automatic logic [5:0] wstrb(input int w);
        case (w)
            0:       return 6'b110000;
            1:       return 6'b001000;
            2:       return 6'b000100;
            3:       return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [31:0] wdata(input logic [103:0] t, input int w);
        case (w)
            0:       return t[103:72];
            1:       return t[71:40];
            2:       return t[39:8];
            3:       return {24'h0, t[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_word(input string tag, input logic [103:0] t, input int w);
        chk({tag, "_strb"}, {26'h0, soh, sa, da, sp_dp, prot, eoh}, {26'h0, wstrb(w)});
        chk({tag, "_data"}, data, wdata(t, w));
    endtask

    // Starts from IDLE at a negedge; sends one header, stalling nstall cycles on word stall_w.
    task automatic send_hdr(input logic [103:0] t, input int stall_w, input int nstall);
        in_tuple = t;
        in_valid = 1'b1;
        hReady   = 1'b1;
        chk("rdy_idle", {31'h0, in_ready}, 32'h1);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            if (w == 0) in_valid = 1'b0;
            chk_word("word", t, w);
            if (w == stall_w) begin
                hReady = 1'b0;
                for (int k = 1; k <= nstall; k++) begin
                    @(negedge clk);
                    chk_word("held", t, w);
                    chk("rdy_stall", {31'h0, in_ready}, 32'h0);
                end
                hReady = 1'b1;
            end
            chk("rdy_word", {31'h0, in_ready}, (w == 3) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        chk_word("idle", t, 4);
        $display("header sent src=%h hdr_cnt=%0d stall_cnt=%0d", t[103:72], hdr_cnt, stall_cnt);
    endtask

    localparam logic [103:0] T1 = {32'h0A000001, 32'hC0A80001, 16'h0050, 16'h1F90, 8'h06};
    localparam logic [103:0] T2 = {32'h11223344, 32'h55667788, 16'h99AA, 16'hBBCC, 8'h11};
    localparam logic [103:0] T3 = {32'hDEADBEEF, 32'hCAFEF00D, 16'h1234, 16'h5678, 8'h3A};

    initial begin
        logic [103:0] b2b [3];
        logic [5:0]   g_strb_exp [8];
        logic         g_rdy_exp [8];
        b2b[0] = T1; b2b[1] = T2; b2b[2] = T3;
        g_strb_exp = '{6'b110000, 6'b001000, 6'b000100, 6'b000011,
                       6'b000000, 6'b000000, 6'b000000, 6'b110000};
        g_rdy_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_strb", {26'h0, soh, sa, da, sp_dp, prot, eoh}, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_rdy", {31'h0, in_ready}, 32'h0);
        chk("rst_hdr", {28'h0, hdr_cnt}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single header, no stall
        send_hdr(T1, 9, 0);
        chk("t1_hdr", {28'h0, hdr_cnt}, 32'h1);

        // Three headers back-to-back, GAP=0
        in_valid = 1'b1;
        in_tuple = b2b[0];
        for (int h = 0; h < 3; h++) begin
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                chk_word("b2b", b2b[h], w);
                chk("b2b_rdy", {31'h0, in_ready}, (w == 3) ? 32'h1 : 32'h0);
                if (w == 2) begin
                    if (h < 2) in_tuple = b2b[h + 1];
                    else       in_valid = 1'b0;
                end
            end
            $display("b2b header %0d src=%h", h, b2b[h][103:72]);
        end
        @(negedge clk);
        chk_word("b2b_end", T3, 4);
        chk("b2b_hdr", {28'h0, hdr_cnt}, 32'h4);

        // Back-pressure on the DA word for 3 cycles
        send_hdr(T2, 1, 3);
        chk("t3_stall", {28'h0, stall_cnt}, 32'h3);
        chk("t3_hdr", {28'h0, hdr_cnt}, 32'h5);

        // Asynchronous reset in the middle of the SPDP word
        in_tuple = T3;
        in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk_word("pre_rst", T3, w);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strb", {26'h0, soh, sa, da, sp_dp, prot, eoh}, 32'h0);
        chk("arst_data", data, 32'h0);
        chk("arst_rdy", {31'h0, in_ready}, 32'h0);
        chk("arst_hdr", {28'h0, hdr_cnt}, 32'h0);
        chk("arst_stall", {28'h0, stall_cnt}, 32'h0);
        @(negedge clk);
        chk("arst_noeoh", {31'h0, eoh}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        send_hdr(T1, 9, 0);
        chk("post_rst_hdr", {28'h0, hdr_cnt}, 32'h1);

        // Counter wrap at CNT_W=4: 17 headers with one stall cycle each
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            send_hdr({32'(i), 32'(i * 3), 16'(i), 16'(~i), 8'(i + 1)}, 1, 1);
        end
        chk("wrap_hdr", {28'h0, hdr_cnt}, 32'h1);
        chk("wrap_stall", {28'h0, stall_cnt}, 32'h1);

        // GAP=2 instance: eoh, two GAP cycles, one IDLE cycle, then soh
        g_valid = 1'b1;
        g_tuple = T1;
        chk("gap_rdy0", {31'h0, g_ready}, 32'h1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("gap_strb", {26'h0, g_soh, g_sa, g_da, g_sp_dp, g_prot, g_eoh},
                {26'h0, g_strb_exp[c]});
            chk("gap_rdy", {31'h0, g_ready}, {31'h0, g_rdy_exp[c]});
            if (c == 0) g_tuple = T2;
            $display("gap cycle %0d strb=%b rdy=%b data=%h", c + 1,
                     {g_soh, g_sa, g_da, g_sp_dp, g_prot, g_eoh}, g_ready, g_data);
        end
        chk("gap_data2", g_data, 32'h11223344);
        chk("gap_hdr", g_hdr_cnt[3:0], 32'h1);
        g_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
